// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT constants, coefficient type and modulus table
package ntt_pkg;

  localparam int COEF_W = 30;

  typedef logic [COEF_W-1:0] coef_t;

  // Default pipeline depth of modular_multiplier; the butterfly's delay line
  // defaults to the same value so the two stay aligned.
  localparam int DEF_MULT_LATENCY = 10;

  localparam int NUM_MODULI = 3;

  // NTT-friendly primes below 2^30 (k*2^m + 1).
  localparam coef_t MODULI [NUM_MODULI] = '{
    30'd998244353,
    30'd754974721,
    30'd469762049
  };

  function automatic coef_t get_modulus(input int idx);
    return MODULI[idx];
  endfunction

endpackage

// File: rtl/mod_add_sub.sv
// rtl/mod_add_sub.sv - combinational modular add/sub: x=(a+t) mod q, y=(a-t) mod q
module mod_add_sub
  import ntt_pkg::*;
(
  input  coef_t a,
  input  coef_t t,
  input  coef_t q,
  output coef_t x,
  output coef_t y
);

  logic [COEF_W:0] a_ext;
  logic [COEF_W:0] t_ext;
  logic [COEF_W:0] q_ext;
  logic [COEF_W:0] s;

  // One conditional subtract for the sum, one conditional add-back for the
  // difference; both stay in 31 bits so the carry/borrow is never lost.
  always_comb begin
    a_ext = {1'b0, a};
    t_ext = {1'b0, t};
    q_ext = {1'b0, q};
    s     = a_ext + t_ext;
    x     = coef_t'((s >= q_ext) ? (s - q_ext) : s);
    y     = coef_t'((a >= t) ? (a_ext - t_ext) : (a_ext - t_ext + q_ext));
  end

endmodule

// File: rtl/modular_multiplier.sv
// rtl/modular_multiplier.sv - c = a*b mod q, fixed LATENCY, no enable, no reset
module modular_multiplier
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX = 0,
  parameter int LATENCY   = DEF_MULT_LATENCY
) (
  input  logic  clk,
  input  coef_t a,
  input  coef_t b,
  output coef_t c
);

  localparam coef_t Q = get_modulus(MOD_INDEX);

  logic [2*COEF_W-1:0] prod;
  logic [2*COEF_W-1:0] prod_mod;

  logic [LATENCY-1:0][COEF_W-1:0] pipe_q;
  logic [LATENCY-1:0][COEF_W-1:0] pipe_d;

  // Full product reduced modulo q, then shifted down the fixed-depth pipe.
  always_comb begin
    prod     = (2*COEF_W)'(a) * (2*COEF_W)'(b);
    prod_mod = prod % (2*COEF_W)'(Q);
    pipe_d   = pipe_q;
    pipe_d[0] = coef_t'(prod_mod);
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Data-only pipeline: validity is tracked by the consumer.
  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
  end

  assign c = pipe_q[LATENCY-1];

endmodule

// File: rtl/ntt_butterfly.sv
// rtl/ntt_butterfly.sv - Cooley-Tukey NTT butterfly; NTT_BUTTERFLY_OUT_REG_EN adds an output register stage
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int MOD_INDEX    = 0,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int TAG_W        = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [29:0]      a,
  input  logic [29:0]      b,
  input  logic [29:0]      w,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [29:0]      x,
  output logic [29:0]      y,
  output logic [TAG_W-1:0] out_tag
);

  localparam coef_t Q = get_modulus(MOD_INDEX);

  coef_t t;

  modular_multiplier #(
    .MOD_INDEX (MOD_INDEX),
    .LATENCY   (MULT_LATENCY)
  ) u_mult (
    .clk (clk),
    .a   (b),
    .b   (w),
    .c   (t)
  );

  logic [MULT_LATENCY-1:0][COEF_W-1:0] a_dly_q,   a_dly_d;
  logic [MULT_LATENCY-1:0][TAG_W-1:0]  tag_dly_q, tag_dly_d;
  logic [MULT_LATENCY-1:0]             vld_dly_q, vld_dly_d;

  // Delay line for a, tag and valid matching the multiplier depth.
  always_comb begin
    a_dly_d      = a_dly_q;
    tag_dly_d    = tag_dly_q;
    vld_dly_d    = vld_dly_q;
    a_dly_d[0]   = a;
    tag_dly_d[0] = in_tag;
    vld_dly_d[0] = in_valid;
    for (int i = 1; i < MULT_LATENCY; i++) begin
      a_dly_d[i]   = a_dly_q[i-1];
      tag_dly_d[i] = tag_dly_q[i-1];
      vld_dly_d[i] = vld_dly_q[i-1];
    end
  end

  // Delay-line registers; reset clears valids so in-flight work is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dly_q   <= '0;
      tag_dly_q <= '0;
      vld_dly_q <= '0;
    end else begin
      a_dly_q   <= a_dly_d;
      tag_dly_q <= tag_dly_d;
      vld_dly_q <= vld_dly_d;
    end
  end

  // Align stage: delayed a meets multiplier output t in the same cycle.
  coef_t            a_al;
  logic [TAG_W-1:0] tag_al;
  logic             vld_al;
  coef_t            x_sum;
  coef_t            y_diff;

  assign a_al   = a_dly_q[MULT_LATENCY-1];
  assign tag_al = tag_dly_q[MULT_LATENCY-1];
  assign vld_al = vld_dly_q[MULT_LATENCY-1];

  mod_add_sub u_add_sub (
    .a (a_al),
    .t (t),
    .q (Q),
    .x (x_sum),
    .y (y_diff)
  );

  logic             vld_q, vld_d;
  coef_t            x_q,   x_d;
  coef_t            y_q,   y_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  // Results load only for valid butterflies and hold otherwise.
  always_comb begin
    vld_d = vld_al;
    x_d   = x_q;
    y_d   = y_q;
    tag_d = tag_q;
    if (vld_al) begin
      x_d   = x_sum;
      y_d   = y_diff;
      tag_d = tag_al;
    end
  end

  // Add/sub result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      x_q   <= x_d;
      y_q   <= y_d;
      tag_q <= tag_d;
    end
  end

`ifdef NTT_BUTTERFLY_OUT_REG_EN
  logic             o_vld_q, o_vld_d;
  coef_t            o_x_q,   o_x_d;
  coef_t            o_y_q,   o_y_d;
  logic [TAG_W-1:0] o_tag_q, o_tag_d;

  // Retiming copy of the add/sub registers for the write-back path.
  always_comb begin
    o_vld_d = vld_q;
    o_x_d   = x_q;
    o_y_d   = y_q;
    o_tag_d = tag_q;
  end

  // Extra output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_vld_q <= 1'b0;
      o_x_q   <= '0;
      o_y_q   <= '0;
      o_tag_q <= '0;
    end else begin
      o_vld_q <= o_vld_d;
      o_x_q   <= o_x_d;
      o_y_q   <= o_y_d;
      o_tag_q <= o_tag_d;
    end
  end

  assign out_valid = o_vld_q;
  assign x         = o_x_q;
  assign y         = o_y_q;
  assign out_tag   = o_tag_q;
`else
  assign out_valid = vld_q;
  assign x         = x_q;
  assign y         = y_q;
  assign out_tag   = tag_q;
`endif

endmodule

// File: tb/tb_ntt_butterfly.sv
// tb/tb_ntt_butterfly.sv - scoreboard bench for ntt_butterfly
module tb_ntt_butterfly;

  localparam int MULT_LATENCY = 10;
  localparam int TAG_W        = 10;
  localparam longint unsigned Q = 64'd998244353;
`ifdef NTT_BUTTERFLY_OUT_REG_EN
  localparam int LAT_TOT = MULT_LATENCY + 2;
`else
  localparam int LAT_TOT = MULT_LATENCY + 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [29:0]      a;
  logic [29:0]      b;
  logic [29:0]      w;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [29:0]      x;
  logic [29:0]      y;
  logic [TAG_W-1:0] out_tag;

  ntt_butterfly #(
    .MOD_INDEX    (0),
    .MULT_LATENCY (MULT_LATENCY),
    .TAG_W        (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .w         (w),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .x         (x),
    .y         (y),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             v;
    logic [29:0]      x;
    logic [29:0]      y;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q[$];
  logic [29:0]      hold_x;
  logic [29:0]      hold_y;
  logic [TAG_W-1:0] hold_tag;
  int               checks;
  int               failures;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reset-state model: empty pipeline represented by LAT_TOT-1 bubbles.
  task automatic model_reset();
    exp_t e;
    e = '0;
    exp_q.delete();
    for (int i = 0; i < LAT_TOT - 1; i++) exp_q.push_back(e);
    hold_x   = '0;
    hold_y   = '0;
    hold_tag = '0;
  endtask

  task automatic step(input logic v, input longint unsigned av, input longint unsigned bv,
                      input longint unsigned wv, input logic [TAG_W-1:0] tg);
    exp_t e;
    longint unsigned t;
    in_valid = v;
    a        = 30'(av);
    b        = 30'(bv);
    w        = 30'(wv);
    in_tag   = tg;
    t     = (bv * wv) % Q;
    e.v   = v;
    e.x   = 30'((av + t) % Q);
    e.y   = 30'((av + Q - t) % Q);
    e.tag = tg;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.v) begin
      hold_x   = e.x;
      hold_y   = e.y;
      hold_tag = e.tag;
    end
    chk("out_valid", 64'(out_valid), 64'(e.v));
    chk("x",         64'(x),         64'(hold_x));
    chk("y",         64'(y),         64'(hold_y));
    chk("out_tag",   64'(out_tag),   64'(hold_tag));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, '0);
  endtask

  task automatic rand_vec(input logic v);
    step(v, longint'($urandom_range(0, 32'(Q - 1))), longint'($urandom_range(0, 32'(Q - 1))),
         longint'($urandom_range(0, 32'(Q - 1))), TAG_W'($urandom));
  endtask

  // Hold reset for n cycles with random valid traffic, expecting all-zero outputs.
  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      a        = 30'($urandom_range(0, 32'(Q - 1)));
      b        = 30'($urandom_range(0, 32'(Q - 1)));
      w        = 30'($urandom_range(0, 32'(Q - 1)));
      in_tag   = TAG_W'($urandom);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_x",         64'(x),         64'd0);
      chk("rst_y",         64'(y),         64'd0);
      chk("rst_out_tag",   64'(out_tag),   64'd0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] pattern;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    w        = '0;
    in_tag   = '0;
    pattern  = 8'b1101_0011;
    model_reset();
    #1;

    // Reset with traffic, then quiet outputs for the full latency.
    reset_cycles(5);
    idle(LAT_TOT);

    // Basic: x = 26, y = q - 16, tag 0x12.
    step(1'b1, 5, 3, 7, 10'h012);
    idle(LAT_TOT + 2);

    // Wrap boundaries.
    step(1'b1, Q - 1, 1, 1, 10'h001);
    step(1'b1, 0,     1, 1, 10'h002);
    step(1'b1, 7,     7, 1, 10'h003);
    idle(LAT_TOT + 1);

    // Stream of 64 random vectors with a gapped valid pattern.
    for (int i = 0; i < 64; i++) rand_vec(pattern[7 - (i % 8)]);
    idle(LAT_TOT + 1);

    // Mid-stream reset drops six in-flight butterflies.
    for (int i = 0; i < 6; i++) rand_vec(1'b1);
    reset_cycles(1);
    step(1'b1, 123456, 789012, 345678, 10'h3a5);
    idle(LAT_TOT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly.md
# ntt_butterfly

Cooley-Tukey NTT butterfly that consumes the Montgomery-free modular multiplier output. It computes t = b·w mod q, then x = (a + t) mod q and y = (a − t) mod q. It sits directly downstream of `modular_multiplier`, which it instantiates, and feeds the NTT stage memory write-back. The pipeline is fully pipelined: one butterfly accepted per cycle, with no backpressure.

## Interface
- `MOD_INDEX`, default 0: selects modulus q = `MODULI[MOD_INDEX]`; passed unchanged to `modular_multiplier`.
- `MULT_LATENCY`, default 10: fixed cycle latency of `modular_multiplier`, from a/b to c.
- `TAG_W`, default 10: width of the sideband tag (write-back address) carried alongside each butterfly.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: the a/b/w/in_tag inputs are valid this cycle.
- `a` in 30: even operand, must be < q.
- `b` in 30: odd operand, must be < q.
- `w` in 30: twiddle factor, must be < q.
- `in_tag` in TAG_W: sideband, carried unmodified.
- `out_valid` out 1: x/y/out_tag are valid this cycle.
- `x` out 30: (a + b·w) mod q.
- `y` out 30: (a − b·w) mod q.
- `out_tag` out TAG_W: the in_tag of the same butterfly.

## Operation
- b and w drive `modular_multiplier` directly every cycle. The multiplier has no enable and no reset, so its pipeline contents are meaningful only where the valid chain says so.
- a, in_tag and in_valid enter a MULT_LATENCY-deep delay line. The a and tag registers shift unconditionally. The valid bits are reset to 0.
- The align stage pairs delayed a with multiplier output t in the same cycle.
- Add/sub stage, registered:
  - s = a + t, 31-bit. x = s − q if s ≥ q, else s.
  - d = a − t when a ≥ t, else a − t + q, computed in 31 bits. y = d[29:0].
- x, y and out_tag update only on cycles when the aligned valid is 1. Otherwise they hold their previous values. out_valid follows the aligned valid every cycle.
- Out-of-range inputs (≥ q) yield unspecified but non-X values. No error flag is raised.
- There is no stall and no ready signal. The upstream address generator owns scheduling.

## Timing
- Latency: sample in_valid=1 at edge N, then out_valid=1 with results after edge N+MULT_LATENCY+1. The macro adds +1.
- Throughput: 1 butterfly/cycle. Any in_valid pattern is reproduced exactly on out_valid, delayed by the latency.
- Reset values: out_valid=0, x=0, y=0, out_tag=0, all valid-chain bits 0. The a and tag delay registers also reset to 0.
- Reset asserted mid-stream: every in-flight butterfly is dropped, and none emerges after release.
- After release, out_valid stays 0 until a new in_valid has propagated the full latency.
- Boundary: s = q exactly gives x = 0. a = t gives y = 0. a = 0 with t > 0 gives y = q − t.

## Configuration
- `NTT_BUTTERFLY_OUT_REG_EN` defined: an extra output register stage follows add/sub, covering out_valid, x, y and out_tag. It resets to 0 and makes latency MULT_LATENCY+2. It exists for timing closure into BRAM write ports.
- Macro not defined: add/sub registers drive the ports directly, and latency is MULT_LATENCY+1.

## Structure
- Shared package `ntt_pkg` holds:
  - `MODULI` table, 30-bit entries indexed by MOD_INDEX.
  - `COEF_W` = 30.
  - the coefficient typedef `coef_t`.
  - default `MULT_LATENCY` constant, shared with `modular_multiplier` so the two cannot drift.
- One natural sub-module, `mod_add_sub`: combinational a, t, q in, x and y out. The butterfly registers its outputs. The module is reusable for Gentleman-Sande later.
- `modular_multiplier` is instantiated as-is with `#MOD_INDEX`.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with random inputs and in_valid=1 → out_valid=0, x=y=0, out_tag=0 throughout and for MULT_LATENCY+1 cycles after release.
- Basic: a=5, b=3, w=7, tag=0x12 → exactly MULT_LATENCY+1 cycles later out_valid=1, x=26, y=q−16, out_tag=0x12.
- Wrap: a=q−1, b=1, w=1 → x=0, y=q−2. Then a=0, b=1, w=1 → x=1, y=q−1. Then a=7, b=7, w=1 → y=0, x=14.
- Stream: 64 random vectors with in_valid pattern 1101 0011… → identical out_valid pattern delayed. Each x/y/out_tag matches the reference model; x/y hold during gaps.
- Mid-stream reset: pulse rst_n low for 1 cycle with 6 butterflies in flight → none of the 6 appears. The next vector after release emerges correctly.
- Macro build (`NTT_BUTTERFLY_OUT_REG_EN`): repeat the basic test → result arrives at MULT_LATENCY+2 with identical values.
